// File: rtl/rv32_pkg.sv
// Shared definitions for the rv32 register-file write path.
package rv32_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_REGS   = 32;

    // One register-file write-port beat.
    typedef struct packed {
        logic                  en;
        logic [REG_ADDR_W-1:0] addr;
        logic [31:0]           value;
    } rf_write_t;

endpackage

// File: rtl/rv32_scoreboard.sv
// Destination-register ownership for in-flight long-latency ops, with
// decode-side lookups and sticky ordering-error detection.
module rv32_scoreboard
    import rv32_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_ce,
    input  logic                  i_issue_valid,
    input  logic [REG_ADDR_W-1:0] i_issue_rd,
    input  logic                  i_clr_valid,
    input  logic [REG_ADDR_W-1:0] i_clr_rd,
    input  logic [REG_ADDR_W-1:0] i_query_rs1,
    input  logic [REG_ADDR_W-1:0] i_query_rs2,
    input  logic [REG_ADDR_W-1:0] i_query_rd,
    output logic                  o_hazard,
    output logic                  o_err
);

    logic [NUM_REGS-1:0] r_busy;
    logic [NUM_REGS-1:0] w_busy_d;
    logic                r_err;
    logic                w_set;
    logic                w_clr;
    logic                w_err;

    assign w_set = i_issue_valid && (i_issue_rd != '0);
    assign w_clr = i_clr_valid && (i_clr_rd != '0);

    // Next busy vector: clear first so a same-cycle set of the same rd wins.
    always_comb begin
        w_busy_d = r_busy;
        if (w_clr) w_busy_d[i_clr_rd] = 1'b0;
        if (w_set) w_busy_d[i_issue_rd] = 1'b1;
        w_busy_d[0] = 1'b0;
    end

    // Completion of an unowned rd, or a second issue to an owned rd.
    always_comb begin
        w_err = (w_clr && !r_busy[i_clr_rd]) || (w_set && r_busy[i_issue_rd]);
    end

    // Ownership state and sticky error, frozen while the clock enable is low.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_busy <= '0;
            r_err  <= 1'b0;
        end else if (i_ce) begin
            r_busy <= w_busy_d;
            r_err  <= r_err | w_err;
        end
    end

    // Combinational lookups; the rd term covers WAW, x0 is never busy.
    always_comb begin
        o_hazard = r_busy[i_query_rs1] | r_busy[i_query_rs2] | r_busy[i_query_rd];
    end

    assign o_err = r_err;

endmodule

// File: rtl/rv32_rd_write_arbiter.sv
// Shares the register-file write port between the writeback path (always
// wins) and the long-latency unit, with a starvation stall request.
module rv32_rd_write_arbiter
    import rv32_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce_i,
    input  logic        flush_in,
    input  logic        wb_valid_in,
    input  logic        wb_rd_write_in,
    input  logic [4:0]  wb_rd_in,
    input  logic [31:0] wb_rd_value_in,
    input  logic        lu_valid_in,
    output logic        lu_ready_out,
    input  logic [4:0]  lu_rd_in,
    input  logic [31:0] lu_value_in,
    input  logic        issue_valid_in,
    input  logic [4:0]  issue_rd_in,
    input  logic [4:0]  query_rs1_in,
    input  logic [4:0]  query_rs2_in,
    input  logic [4:0]  query_rd_in,
    output logic        hazard_stall_out,
    output logic        starve_stall_out,
    output logic        rf_write_out,
    output logic [4:0]  rf_addr_out,
    output logic [31:0] rf_value_out,
    output logic        protocol_err_out
);

    localparam logic [3:0] CNT_LIMIT = 4'(STARVE_LIMIT);

    logic      w_wb_active;
    logic      w_lu_hs;
    rf_write_t w_rf_d;
    rf_write_t r_rf;
    logic [3:0] w_cnt_d;
    logic [3:0] r_cnt;
    logic      r_starve;

    // A WB request that would produce no write leaves the port to the LU.
    assign w_wb_active  = wb_valid_in && wb_rd_write_in && !flush_in && (wb_rd_in != '0);
    assign lu_ready_out = ce_i && !w_wb_active;
    assign w_lu_hs      = lu_valid_in && lu_ready_out;

    // Port winner; addr/value hold when nothing is written.
    always_comb begin
        w_rf_d    = r_rf;
        w_rf_d.en = 1'b0;
        if (w_lu_hs) begin
            if (lu_rd_in != '0) begin
                w_rf_d.en    = 1'b1;
                w_rf_d.addr  = lu_rd_in;
                w_rf_d.value = lu_value_in;
            end
        end else if (w_wb_active) begin
            w_rf_d.en    = 1'b1;
            w_rf_d.addr  = wb_rd_in;
            w_rf_d.value = wb_rd_value_in;
        end
    end

    // Count consecutive blocked LU cycles, saturating at the limit.
    always_comb begin
        w_cnt_d = r_cnt;
        if (!lu_valid_in || w_lu_hs) begin
            w_cnt_d = '0;
        end else if (r_cnt < CNT_LIMIT) begin
            w_cnt_d = r_cnt + 4'd1;
        end
    end

    // Write-port register, starvation counter and its registered flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rf     <= '0;
            r_cnt    <= '0;
            r_starve <= 1'b0;
        end else if (ce_i) begin
            r_rf     <= w_rf_d;
            r_cnt    <= w_cnt_d;
            r_starve <= (w_cnt_d == CNT_LIMIT);
        end
    end

    rv32_scoreboard u_scoreboard (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_ce          (ce_i),
        .i_issue_valid (issue_valid_in),
        .i_issue_rd    (issue_rd_in),
        .i_clr_valid   (w_lu_hs),
        .i_clr_rd      (lu_rd_in),
        .i_query_rs1   (query_rs1_in),
        .i_query_rs2   (query_rs2_in),
        .i_query_rd    (query_rd_in),
        .o_hazard      (hazard_stall_out),
        .o_err         (protocol_err_out)
    );

    assign rf_write_out     = r_rf.en;
    assign rf_addr_out      = r_rf.addr;
    assign rf_value_out     = r_rf.value;
    assign starve_stall_out = r_starve;

endmodule

// File: tb/tb_rv32_rd_write_arbiter.sv
// Directed bench for rv32_rd_write_arbiter with a behavioural reference model.
module tb_rv32_rd_write_arbiter;

    localparam int unsigned LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        ce_i;
    logic        flush_in;
    logic        wb_valid_in;
    logic        wb_rd_write_in;
    logic [4:0]  wb_rd_in;
    logic [31:0] wb_rd_value_in;
    logic        lu_valid_in;
    logic        lu_ready_out;
    logic [4:0]  lu_rd_in;
    logic [31:0] lu_value_in;
    logic        issue_valid_in;
    logic [4:0]  issue_rd_in;
    logic [4:0]  query_rs1_in;
    logic [4:0]  query_rs2_in;
    logic [4:0]  query_rd_in;
    logic        hazard_stall_out;
    logic        starve_stall_out;
    logic        rf_write_out;
    logic [4:0]  rf_addr_out;
    logic [31:0] rf_value_out;
    logic        protocol_err_out;

    int n_tests = 0;
    int n_fail  = 0;

    rv32_rd_write_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk              (clk),
        .reset            (reset),
        .ce_i             (ce_i),
        .flush_in         (flush_in),
        .wb_valid_in      (wb_valid_in),
        .wb_rd_write_in   (wb_rd_write_in),
        .wb_rd_in         (wb_rd_in),
        .wb_rd_value_in   (wb_rd_value_in),
        .lu_valid_in      (lu_valid_in),
        .lu_ready_out     (lu_ready_out),
        .lu_rd_in         (lu_rd_in),
        .lu_value_in      (lu_value_in),
        .issue_valid_in   (issue_valid_in),
        .issue_rd_in      (issue_rd_in),
        .query_rs1_in     (query_rs1_in),
        .query_rs2_in     (query_rs2_in),
        .query_rd_in      (query_rd_in),
        .hazard_stall_out (hazard_stall_out),
        .starve_stall_out (starve_stall_out),
        .rf_write_out     (rf_write_out),
        .rf_addr_out      (rf_addr_out),
        .rf_value_out     (rf_value_out),
        .protocol_err_out (protocol_err_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit          m_valid = 0;
    bit          m_busy [32];
    int          m_blocked;
    bit          m_starve, m_err, m_wr;
    logic [4:0]  m_addr;
    logic [31:0] m_val;

    function automatic bit wb_wants_port();
        return wb_valid_in && wb_rd_write_in && !flush_in && wb_rd_in != 0;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            foreach (m_busy[i]) m_busy[i] = 0;
            m_blocked = 0; m_starve = 0; m_err = 0;
            m_wr = 0; m_addr = 0; m_val = 0;
            m_valid = 1;
        end else if (ce_i && m_valid) begin
            bit lu_wins;
            bit issue_ok;
            lu_wins  = lu_valid_in && !wb_wants_port();
            issue_ok = issue_valid_in && issue_rd_in != 0;
            if (issue_ok && m_busy[issue_rd_in]) m_err = 1;
            if (lu_wins && lu_rd_in != 0 && !m_busy[lu_rd_in]) m_err = 1;
            m_wr = 0;
            if (lu_wins) begin
                if (lu_rd_in != 0) begin
                    m_wr = 1; m_addr = lu_rd_in; m_val = lu_value_in;
                    m_busy[lu_rd_in] = 0;
                end
            end else if (wb_wants_port()) begin
                m_wr = 1; m_addr = wb_rd_in; m_val = wb_rd_value_in;
            end
            if (issue_ok) m_busy[issue_rd_in] = 1;
            if (lu_valid_in && !lu_wins) m_blocked = (m_blocked < LIMIT) ? m_blocked + 1 : LIMIT;
            else m_blocked = 0;
            m_starve = (m_blocked == LIMIT);
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (m_valid && !reset) begin
            bit hz;
            hz = (query_rs1_in != 0 && m_busy[query_rs1_in]) ||
                 (query_rs2_in != 0 && m_busy[query_rs2_in]) ||
                 (query_rd_in  != 0 && m_busy[query_rd_in]);
            chk("m_rf_write", 32'(rf_write_out), 32'(m_wr));
            chk("m_rf_addr", 32'(rf_addr_out), 32'(m_addr));
            chk("m_rf_value", rf_value_out, m_val);
            chk("m_lu_ready", 32'(lu_ready_out), 32'(ce_i && !wb_wants_port()));
            chk("m_hazard", 32'(hazard_stall_out), 32'(hz));
            chk("m_starve", 32'(starve_stall_out), 32'(m_starve));
            chk("m_err", 32'(protocol_err_out), 32'(m_err));
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle();
        ce_i = 1; flush_in = 0;
        wb_valid_in = 0; wb_rd_write_in = 0; wb_rd_in = 0; wb_rd_value_in = 0;
        lu_valid_in = 0; lu_rd_in = 0; lu_value_in = 0;
        issue_valid_in = 0; issue_rd_in = 0;
        query_rs1_in = 0; query_rs2_in = 0; query_rd_in = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb(input logic [4:0] rd, input logic [31:0] v);
        wb_valid_in = 1; wb_rd_write_in = 1; wb_rd_in = rd; wb_rd_value_in = v;
    endtask

    task automatic issue(input logic [4:0] rd);
        issue_valid_in = 1; issue_rd_in = rd; tick(); issue_valid_in = 0;
    endtask

    initial begin
        idle();
        reset = 1;
        tick(); tick();
        reset = 0;
        chk("rst_write", 32'(rf_write_out), 0);
        chk("rst_value", rf_value_out, 0);
        chk("rst_err", 32'(protocol_err_out), 0);

        // WB only
        wb(5, 32'hDEADBEEF); tick(); idle();
        chk("wb_write", 32'(rf_write_out), 1);
        chk("wb_addr", 32'(rf_addr_out), 5);
        chk("wb_value", rf_value_out, 32'hDEADBEEF);
        wb(0, 32'h1234); #1;
        chk("wb_x0_ready", 32'(lu_ready_out), 1);
        tick(); idle();
        chk("wb_x0_nowrite", 32'(rf_write_out), 0);

        // Conflict
        issue(7);
        wb(3, 32'h33); lu_valid_in = 1; lu_rd_in = 7; lu_value_in = 32'h77; #1;
        chk("conf_ready", 32'(lu_ready_out), 0);
        tick(); wb_valid_in = 0; query_rd_in = 7;
        chk("conf_wb_addr", 32'(rf_addr_out), 3);
        #1;
        chk("conf_lu_ready", 32'(lu_ready_out), 1);
        chk("conf_waw", 32'(hazard_stall_out), 1);
        tick(); lu_valid_in = 0;
        chk("conf_lu_addr", 32'(rf_addr_out), 7);
        chk("conf_lu_value", rf_value_out, 32'h77);
        chk("conf_busy_clr", 32'(hazard_stall_out), 0);
        idle();

        // Scoreboard
        issue(9); query_rs2_in = 9; #1;
        chk("sb_hazard", 32'(hazard_stall_out), 1);
        tick(); tick();
        lu_valid_in = 1; lu_rd_in = 9; lu_value_in = 32'h99; tick(); lu_valid_in = 0;
        chk("sb_hazard_clr", 32'(hazard_stall_out), 0);
        issue(9);
        issue_valid_in = 1; issue_rd_in = 9; lu_valid_in = 1; lu_rd_in = 9; tick();
        issue_valid_in = 0; lu_valid_in = 0;
        chk("sb_set_wins", 32'(hazard_stall_out), 1);
        chk("sb_reissue_err", 32'(protocol_err_out), 1);
        issue(10); issue(11);
        reset = 1; tick(); reset = 0;
        query_rs1_in = 10; query_rd_in = 11; #1;
        chk("rst_busy", 32'(hazard_stall_out), 0);
        chk("rst_err_clr", 32'(protocol_err_out), 0);
        chk("rst_write2", 32'(rf_write_out), 0);
        idle();

        // Starvation
        issue(13);
        lu_valid_in = 1; lu_rd_in = 13; lu_value_in = 32'hD13;
        for (int i = 0; i < 4; i++) begin
            wb(6, 32'h600 + i);
            tick();
            if (i == 2) chk("starve_early", 32'(starve_stall_out), 0);
        end
        chk("starve_set", 32'(starve_stall_out), 1);
        wb_valid_in = 0; tick(); lu_valid_in = 0;
        chk("starve_hs_addr", 32'(rf_addr_out), 13);
        chk("starve_drop", 32'(starve_stall_out), 0);
        idle();

        // Flush
        issue(14);
        wb(4, 32'h44); flush_in = 1; #1;
        chk("flush_ready", 32'(lu_ready_out), 1);
        tick(); idle(); query_rs1_in = 14; #1;
        chk("flush_nowrite", 32'(rf_write_out), 0);
        chk("flush_busy", 32'(hazard_stall_out), 1);

        // Clock enable low
        wb(2, 32'h22); tick();
        ce_i = 0; wb(8, 32'h88); issue_valid_in = 1; issue_rd_in = 15;
        lu_valid_in = 1; lu_rd_in = 14;
        tick(); tick(); tick();
        chk("ce_ready", 32'(lu_ready_out), 0);
        chk("ce_hold_write", 32'(rf_write_out), 1);
        chk("ce_hold_addr", 32'(rf_addr_out), 2);
        idle(); query_rs1_in = 14; query_rs2_in = 15; #1;
        chk("ce_busy_frozen", 32'(hazard_stall_out), 1);
        query_rs1_in = 0; #1;
        chk("ce_no_issue", 32'(hazard_stall_out), 0);

        // Completion to non-busy x12
        lu_valid_in = 1; lu_rd_in = 12; lu_value_in = 32'hC12; tick(); idle();
        chk("err_set", 32'(protocol_err_out), 1);
        tick(); tick();
        chk("err_sticky", 32'(protocol_err_out), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
